// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/rsp handshake and IF/ID register.
// Optional one-entry skid buffer under freeze: define IF_SKID_BUF_EN.
module if_stage #(
    parameter int                  WORD_LEN  = 16,
    parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
    parameter logic [WORD_LEN-1:0] NOP_INSTR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brTaken,
    input  logic [WORD_LEN-1:0] br_target,
    input  logic                jumpEnable,
    input  logic [WORD_LEN-1:0] jump_target,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic                imem_rready,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] pc_out,
    output logic                if_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] pc_nxt;
    logic [WORD_LEN-1:0] pc_inc;
    logic [WORD_LEN-1:0] target;
    logic                redirect;
    logic                hold;
    logic                take;
    logic                grant;
    logic                wait_take;

`ifdef IF_SKID_BUF_EN
    logic                skid_full;
    logic [WORD_LEN-1:0] skid_instr;
    logic [WORD_LEN-1:0] skid_pc;
`endif

    assign redirect  = jumpEnable | brTaken;
    assign target    = jumpEnable ? jump_target : br_target;
    assign pc_inc    = pc + WORD_LEN'(1);
    assign hold      = freeze & if_valid;
    assign take      = imem_rvalid & imem_rready;
    assign grant     = imem_req & imem_gnt;
    assign wait_take = (state == S_WAIT) & take;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                if (grant)
                    state_nxt = redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (take)
                    state_nxt = S_REQ;
                else if (redirect)
                    state_nxt = S_DROP;
            end
            S_DROP: begin
                if (take)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // rready is forced low while reset is asserted, whatever the state
    always_comb begin
        imem_req    = 1'b0;
        imem_rready = 1'b0;
        unique case (state)
            S_REQ: begin
                imem_req    = 1'b1;
                imem_rready = rst;
            end
            S_WAIT: begin
`ifdef IF_SKID_BUF_EN
                imem_rready = rst & ~skid_full;
`else
                imem_rready = rst & ~hold;
`endif
            end
            S_DROP: imem_rready = rst;
            default: ;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (redirect)
            pc_nxt = target;
        else if (wait_take)
            pc_nxt = pc_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            if_valid    <= 1'b0;
        end else if (redirect) begin
            instruction <= NOP_INSTR;
            pc_out      <= '0;
            if_valid    <= 1'b0;
        end else if (hold) begin
            instruction <= instruction;
`ifdef IF_SKID_BUF_EN
        end else if (skid_full) begin
            instruction <= skid_instr;
            pc_out      <= skid_pc;
            if_valid    <= 1'b1;
`endif
        end else if (wait_take) begin
            instruction <= imem_rdata;
            pc_out      <= pc_inc;
            if_valid    <= 1'b1;
        end else begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
        end
    end

`ifdef IF_SKID_BUF_EN
    // A response taken while IF/ID is held parks here so fetch can run ahead
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_full  <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else if (redirect) begin
            skid_full  <= 1'b0;
        end else if (hold & wait_take) begin
            skid_full  <= 1'b1;
            skid_instr <= imem_rdata;
            skid_pc    <= pc_inc;
        end else if (!hold & skid_full) begin
            skid_full  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable memory model
// and an address scoreboard checked at the IF/ID output.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        br_taken = 1'b0;
    logic        jump_en = 1'b0;
    logic        gnt = 1'b1;
    logic [15:0] br_target = '0;
    logic [15:0] jump_target = '0;
    logic        rvalid;
    logic [15:0] rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rready;
    logic [15:0] instruction;
    logic [15:0] pc_out;
    logic        if_valid;

    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] q[$];
    logic [15:0] sb_e;
    int          lat = 1;
    int          mcnt;
    logic [15:0] maddr;

    if_stage dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .brTaken(br_taken),
        .br_target(br_target),
        .jumpEnable(jump_en),
        .jump_target(jump_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(gnt),
        .imem_rvalid(rvalid),
        .imem_rdata(rdata),
        .imem_rready(imem_rready),
        .instruction(instruction),
        .pc_out(pc_out),
        .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    // memory: response lat cycles after grant, held until taken
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            mcnt   <= 0;
            maddr  <= '0;
        end else begin
            if (rvalid && imem_rready)
                rvalid <= 1'b0;
            if (mcnt == 1) begin
                rvalid <= 1'b1;
                rdata  <= maddr ^ 16'hA000;
                mcnt   <= 0;
            end else if (mcnt > 1) begin
                mcnt <= mcnt - 1;
            end
            if (imem_req && gnt) begin
                maddr <= imem_addr;
                if (lat == 1) begin
                    rvalid <= 1'b1;
                    rdata  <= imem_addr ^ 16'hA000;
                end else begin
                    mcnt <= lat - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // decode consumes a valid entry on every unfrozen, non-redirect cycle
    always @(negedge clk) begin
        if (rst && if_valid && !freeze && !br_taken && !jump_en) begin
            if (q.size() == 0) begin
                check("unexpected_valid", {15'd0, if_valid}, 16'd0);
            end else begin
                sb_e = q.pop_front();
                check("sb_instr", instruction, sb_e ^ 16'hA000);
                check("sb_pc", pc_out, sb_e + 16'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, {15'd0, if_valid}, 16'd1);
    endtask

    task automatic stop_at(input logic [15:0] a);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 40) begin
            tick();
            n++;
        end
        check("stop_addr", imem_addr, a);
        check("stop_req", {15'd0, imem_req}, 16'd1);
        gnt = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain", 16'(q.size()), 16'd0);
    endtask

    initial begin
        #2;
        check("rst_instr", instruction, 16'h0000);
        check("rst_pc_out", pc_out, 16'h0000);
        check("rst_valid", {15'd0, if_valid}, 16'd0);
        check("rst_rready", {15'd0, imem_rready}, 16'd0);
        check("rst_addr", imem_addr, 16'h0000);

        // streaming fetch, 1-cycle memory
        q.push_back(16'h0000);
        q.push_back(16'h0001);
        q.push_back(16'h0002);
        tick();
        rst = 1'b1;
        wait_valid("first_valid");
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("pulse", {15'd0, if_valid}, (i % 2 == 0) ? 16'd1 : 16'd0);
        end
        stop_at(16'h0003);
        drain();

`ifdef IF_SKID_BUF_EN
        q.push_back(16'h0003);
        q.push_back(16'h0004);
        q.push_back(16'h0005);
        gnt = 1'b1;
        wait_valid("skid_valid");
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0)
                check("skid_rready_empty", {15'd0, imem_rready}, 16'd1);
            if (i == 1) begin
                check("skid_req", {15'd0, imem_req}, 16'd1);
                check("skid_addr", imem_addr, 16'h0005);
            end
            if (i == 2)
                check("skid_rready_full", {15'd0, imem_rready}, 16'd0);
            if (i == 4)
                check("skid_hold", instruction, 16'hA003);
        end
        freeze = 1'b0;
        tick();
        check("skid_out_instr", instruction, 16'hA004);
        check("skid_out_pc", pc_out, 16'h0005);
        stop_at(16'h0006);
        drain();
`else
        // freeze with a pending response
        q.push_back(16'h0003);
        q.push_back(16'h0004);
        gnt = 1'b1;
        wait_valid("frz_valid");
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("frz_rready", {15'd0, imem_rready}, 16'd0);
            check("frz_instr", instruction, 16'hA003);
            check("frz_pc", pc_out, 16'h0004);
        end
        freeze = 1'b0;
        stop_at(16'h0005);
        drain();
`endif

        // branch redirect while WAIT, stale response later
        lat = 4;
        gnt = 1'b1;
        tick();
        check("br_wait", {15'd0, imem_req}, 16'd0);
        br_taken  = 1'b1;
        br_target = 16'h0040;
        tick();
        br_taken = 1'b0;
        check("br_valid", {15'd0, if_valid}, 16'd0);
        check("br_instr", instruction, 16'h0000);
        check("br_pc_out", pc_out, 16'h0000);
        check("br_drop", {15'd0, imem_req}, 16'd0);
        repeat (3) tick();
        check("br_req", {15'd0, imem_req}, 16'd1);
        check("br_addr", imem_addr, 16'h0040);
        gnt = 1'b0;

        // jump + branch + freeze together
        lat = 1;
        gnt = 1'b1;
        wait_valid("jb_valid");
        check("jb_pre", instruction, 16'hA040);
        freeze      = 1'b1;
        jump_en     = 1'b1;
        jump_target = 16'h0100;
        br_taken    = 1'b1;
        br_target   = 16'h0200;
        gnt         = 1'b0;
        tick();
        check("jb_valid0", {15'd0, if_valid}, 16'd0);
        check("jb_instr", instruction, 16'h0000);
        check("jb_pc_out", pc_out, 16'h0000);
        check("jb_addr", imem_addr, 16'h0100);
        freeze   = 1'b0;
        jump_en  = 1'b0;
        br_taken = 1'b0;

        // PC wrap
        jump_en     = 1'b1;
        jump_target = 16'hFFFF;
        tick();
        jump_en = 1'b0;
        check("wrap_addr", imem_addr, 16'hFFFF);
        q.push_back(16'hFFFF);
        gnt = 1'b1;
        stop_at(16'h0000);
        drain();

        // async reset in WAIT with IF/ID held
        gnt = 1'b1;
        wait_valid("ar_valid");
        freeze = 1'b1;
        lat    = 4;
        tick();
        check("ar_wait", {15'd0, imem_req}, 16'd0);
        check("ar_held", instruction, 16'hA000);
        #2;
        rst = 1'b0;
        #1;
        check("ar_instr", instruction, 16'h0000);
        check("ar_pc_out", pc_out, 16'h0000);
        check("ar_valid", {15'd0, if_valid}, 16'd0);
        check("ar_rready", {15'd0, imem_rready}, 16'd0);
        check("ar_addr", imem_addr, 16'h0000);
        freeze = 1'b0;
        lat    = 1;
        q.push_back(16'h0000);
        tick();
        rst = 1'b1;
        stop_at(16'h0001);
        drain();

        check("sb_left", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
